feedback_state_reg: RTL

//  Parametrised registered successor to the 64-bit bitwise feedback mux, for iterative cipher datapaths.

---
 rtl/feedback_state_reg_if.sv | 51 +++++
 rtl/feedback_state_reg.sv | 113 +++++++++++
 2 files changed

// File: rtl/feedback_state_reg_if.sv
// Handshake and datapath bundle for feedback_state_reg.
// The slave modport is the block itself; the master modport is the surrounding datapath.
interface feedback_state_reg_if #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ROUNDS = 10
);
  localparam int unsigned CW = $clog2(ROUNDS + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] fb_data;
  logic [WIDTH-1:0] upd_mask;
  logic [WIDTH-1:0] state_q;
  logic [CW-1:0]    rnd_idx;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  fb_data,
    input  upd_mask,
    input  out_ready,
    output in_ready,
    output state_q,
    output rnd_idx,
    output busy,
    output out_valid,
    output out_data
  );

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output fb_data,
    output upd_mask,
    output out_ready,
    input  in_ready,
    input  state_q,
    input  rnd_idx,
    input  busy,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/feedback_state_reg.sv
// Registered cipher-state holder for iterative round datapaths.
// Loads an initial state, merges the round-function output under a per-bit mask
// for ROUNDS cycles, then presents the result on a valid/ready output.
module feedback_state_reg #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ROUNDS = 10
) (
  input logic                 clk,
  input logic                 rst,
  feedback_state_reg_if.slave bus
);
  localparam int unsigned   CW      = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LastRnd = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } st_e;

  st_e              st_q, st_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    rnd_q, rnd_d;
  // High for the first cycle after reset; keeps in_ready low while reset is
  // applied and for the edge right after it, so in_ready is a pure register decode.
  logic             rst_hold_q;

  logic             idle_rdy;
  logic             accept;
  logic             last_rnd;
  logic [WIDTH-1:0] merged;

  assign idle_rdy = (st_q == StIdle) && !rst_hold_q;
  assign accept   = idle_rdy && bus.in_valid;
  assign last_rnd = (rnd_q == LastRnd);
  // Per-bit select: 1 takes the round-function bit, 0 keeps the current bit.
  assign merged   = (~bus.upd_mask & data_q) | (bus.upd_mask & bus.fb_data);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= StIdle;
      data_q     <= '0;
      rnd_q      <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      st_q       <= st_d;
      data_q     <= data_d;
      rnd_q      <= rnd_d;
      rst_hold_q <= 1'b0;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    rnd_d  = rnd_q;
    if (bus.flush) begin
      st_d   = StIdle;
      data_d = '0;
      rnd_d  = '0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (accept) begin
            st_d   = StRun;
            data_d = bus.in_data;
            rnd_d  = '0;
          end
        end
        StRun: begin
          data_d = merged;
          if (last_rnd) begin
            st_d  = StDone;
            rnd_d = '0;
          end else begin
            rnd_d = rnd_q + CW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            st_d = StIdle;
          end
        end
        default: begin
          st_d   = StIdle;
          data_d = '0;
          rnd_d  = '0;
        end
      endcase
    end
  end

  // Output decodes, all from registered state.
  always_comb begin
    bus.in_ready  = idle_rdy;
    bus.busy      = (st_q == StRun);
    bus.out_valid = (st_q == StDone);
    bus.state_q   = data_q;
    bus.out_data  = data_q;
    bus.rnd_idx   = rnd_q;
  end

`ifndef SYNTHESIS
  a_rnd_range : assert property (@(posedge clk) disable iff (rst) rnd_q <= LastRnd);

  a_out_hold : assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready && !bus.flush) |=>
    (bus.out_valid && $stable(bus.out_data)));
`endif

endmodule
